// File: rtl/router_reg.sv
// Datapath register block of the 1x3 packet router: header capture, byte streaming to the
// destination FIFO, hold/replay of the byte that arrives while full, and running parity check.
module router_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  lfd_state,
    input  logic                  rst_int_reg,
    output logic                  err,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] header_hold_r;
    logic [DATA_WIDTH-1:0] ffull_hold_r;
    logic [DATA_WIDTH-1:0] int_parity_r;
    logic [DATA_WIDTH-1:0] pkt_parity_r;
    logic                  addr_ok_s;

    function automatic logic [DATA_WIDTH-1:0] parity_acc(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] b
    );
        return acc ^ b;
    endfunction

    // Address 2'b11 is not a valid destination, so its header is never captured.
    assign addr_ok_s = (data_in[1:0] != 2'b11);

    // Header capture and the output byte path, including the byte parked while the FIFO is full.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            header_hold_r <= {DATA_WIDTH{1'b0}};
            ffull_hold_r  <= {DATA_WIDTH{1'b0}};
            dout          <= {DATA_WIDTH{1'b0}};
        end else begin
            if (detect_add && pkt_valid && addr_ok_s) begin
                header_hold_r <= data_in;
            end
            if (lfd_state) begin
                dout <= header_hold_r;
            end else if (ld_state && !fifo_full) begin
                dout <= data_in;
            end else if (ld_state && fifo_full) begin
                ffull_hold_r <= data_in;
            end else if (laf_state) begin
                dout <= ffull_hold_r;
            end
        end
    end

    // Running parity over header and payload, plus capture of the packet's own parity byte.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            int_parity_r <= {DATA_WIDTH{1'b0}};
            pkt_parity_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (detect_add) begin
                int_parity_r <= {DATA_WIDTH{1'b0}};
            end else if (lfd_state) begin
                int_parity_r <= parity_acc(int_parity_r, header_hold_r);
            end else if (ld_state && pkt_valid && !full_state) begin
                int_parity_r <= parity_acc(int_parity_r, data_in);
            end
            if (ld_state && !pkt_valid) begin
                pkt_parity_r <= data_in;
            end
        end
    end

    // Packet-end status flags; err compares once the parity byte has landed.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            parity_done   <= 1'b0;
            low_pkt_valid <= 1'b0;
            err           <= 1'b0;
        end else begin
            if (detect_add) begin
                parity_done <= 1'b0;
            end else if ((ld_state && !fifo_full && !pkt_valid) ||
                         (laf_state && low_pkt_valid && !parity_done)) begin
                parity_done <= 1'b1;
            end
            if (rst_int_reg) begin
                low_pkt_valid <= 1'b0;
            end else if (ld_state && !pkt_valid) begin
                low_pkt_valid <= 1'b1;
            end
            if (detect_add) begin
                err <= 1'b0;
            end else if (parity_done) begin
                err <= (int_parity_r != pkt_parity_r);
            end
        end
    end

endmodule

// File: tb/tb_router_reg.sv
// Bench for router_reg: per-cycle vectors whose expected outputs are queued when driven and
// popped for comparison one clock later.
module tb_router_reg;

    localparam logic [5:0] IDLE = 6'b000000;
    localparam logic [5:0] DA   = 6'b100000;
    localparam logic [5:0] LFD  = 6'b010000;
    localparam logic [5:0] LD   = 6'b001000;
    localparam logic [5:0] FS   = 6'b000100;
    localparam logic [5:0] LAF  = 6'b000010;
    localparam logic [5:0] RIR  = 6'b000001;

    typedef struct {
        logic       rn;
        logic       pv;
        logic [7:0] d;
        logic       ff;
        logic [5:0] fl;
        logic [7:0] e_dout;
        logic       e_err;
        logic       e_pd;
        logic       e_lpv;
    } vec_t;

    logic       clock = 1'b0;
    logic       resetn, pkt_valid, fifo_full;
    logic       detect_add, ld_state, laf_state, full_state, lfd_state, rst_int_reg;
    logic [7:0] data_in;
    logic       err, parity_done, low_pkt_valid;
    logic [7:0] dout;

    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    router_reg #(.DATA_WIDTH(8)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
        .rst_int_reg(rst_int_reg), .err(err), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .dout(dout)
    );

    always #5 clock = ~clock;

    function automatic vec_t v(input logic rn, input logic pv, input logic [7:0] d,
                               input logic ff, input logic [5:0] fl, input logic [7:0] ed,
                               input logic ee, input logic epd, input logic elpv);
        vec_t r;
        r.rn = rn; r.pv = pv; r.d = d; r.ff = ff; r.fl = fl;
        r.e_dout = ed; r.e_err = ee; r.e_pd = epd; r.e_lpv = elpv;
        return r;
    endfunction

    task automatic check1(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL step %0d %s: got %h expected %h", step_no, name, act, req);
        end
    endtask

    task automatic step(input vec_t x);
        vec_t e;
        @(negedge clock);
        resetn = x.rn; pkt_valid = x.pv; data_in = x.d; fifo_full = x.ff;
        {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg} = x.fl;
        exp_q.push_back(x);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check1("dout", dout, e.e_dout);
        check1("err", {7'd0, err}, {7'd0, e.e_err});
        check1("parity_done", {7'd0, parity_done}, {7'd0, e.e_pd});
        check1("low_pkt_valid", {7'd0, low_pkt_valid}, {7'd0, e.e_lpv});
        step_no++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, good packet (parity 17), bad packet (parity 2E)
        tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b0, IDLE, 8'h00, 1'b0, 1'b0, 1'b0));
        for (int p = 0; p < 2; p++) begin
            tbl.push_back(v(1'b1, 1'b1, 8'h16, 1'b0, DA,  (p == 0) ? 8'h00 : 8'h17,
                            1'b0, 1'b0, 1'b0));
            tbl.push_back(v(1'b1, 1'b1, 8'h16, 1'b0, LFD, 8'h16, 1'b0, 1'b0, 1'b0));
            for (int b = 1; b <= 5; b++)
                tbl.push_back(v(1'b1, 1'b1, 8'(b), 1'b0, LD, 8'(b), 1'b0, 1'b0, 1'b0));
            if (p == 0) begin
                tbl.push_back(v(1'b1, 1'b0, 8'h17, 1'b0, LD,   8'h17, 1'b0, 1'b1, 1'b1));
                tbl.push_back(v(1'b1, 1'b0, 8'h00, 1'b0, IDLE, 8'h17, 1'b0, 1'b1, 1'b1));
                tbl.push_back(v(1'b1, 1'b0, 8'h00, 1'b0, RIR,  8'h17, 1'b0, 1'b1, 1'b0));
            end else begin
                tbl.push_back(v(1'b1, 1'b0, 8'h2E, 1'b0, LD,   8'h2E, 1'b0, 1'b1, 1'b1));
                tbl.push_back(v(1'b1, 1'b0, 8'h00, 1'b0, IDLE, 8'h2E, 1'b1, 1'b1, 1'b1));
                tbl.push_back(v(1'b1, 1'b0, 8'h00, 1'b0, RIR,  8'h2E, 1'b1, 1'b1, 1'b0));
                tbl.push_back(v(1'b1, 1'b0, 8'h00, 1'b0, IDLE, 8'h2E, 1'b1, 1'b1, 1'b0));
            end
        end
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // FIFO full mid-payload: AA parked and replayed; parity byte BD also arrives while full
        step(v(1'b1, 1'b1, 8'h16, 1'b0, DA,   8'h2E, 1'b0, 1'b0, 1'b0));
        step(v(1'b1, 1'b1, 8'h16, 1'b0, LFD,  8'h16, 1'b0, 1'b0, 1'b0));
        step(v(1'b1, 1'b1, 8'h01, 1'b0, LD,   8'h01, 1'b0, 1'b0, 1'b0));
        step(v(1'b1, 1'b1, 8'hAA, 1'b1, LD,   8'h01, 1'b0, 1'b0, 1'b0));
        step(v(1'b1, 1'b1, 8'hAA, 1'b1, FS,   8'h01, 1'b0, 1'b0, 1'b0));
        step(v(1'b1, 1'b1, 8'hAA, 1'b0, LAF,  8'hAA, 1'b0, 1'b0, 1'b0));
        step(v(1'b1, 1'b0, 8'hBD, 1'b1, LD,   8'hAA, 1'b0, 1'b0, 1'b1));
        step(v(1'b1, 1'b0, 8'hBD, 1'b1, FS,   8'hAA, 1'b0, 1'b0, 1'b1));
        step(v(1'b1, 1'b0, 8'hBD, 1'b0, LAF,  8'hBD, 1'b0, 1'b1, 1'b1));
        step(v(1'b1, 1'b0, 8'h00, 1'b0, IDLE, 8'hBD, 1'b0, 1'b1, 1'b1));
        step(v(1'b1, 1'b0, 8'h00, 1'b0, RIR,  8'hBD, 1'b0, 1'b1, 1'b0));

        // Address 3 header is ignored: previous header 16 is still emitted at lfd
        step(v(1'b1, 1'b1, 8'h17, 1'b0, DA,   8'hBD, 1'b0, 1'b0, 1'b0));
        step(v(1'b1, 1'b1, 8'h17, 1'b0, LFD,  8'h16, 1'b0, 1'b0, 1'b0));

        // Reset mid-packet wins over ld, and clears the held header
        step(v(1'b1, 1'b1, 8'h01, 1'b0, LD,   8'h01, 1'b0, 1'b0, 1'b0));
        step(v(1'b0, 1'b0, 8'h55, 1'b0, LD,   8'h00, 1'b0, 1'b0, 1'b0));
        step(v(1'b1, 1'b1, 8'h16, 1'b0, LFD,  8'h00, 1'b0, 1'b0, 1'b0));

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
